// File: rtl/tremolo_pkg.sv
// Shared types and helpers for the tremolo amplitude-modulation stage.
// Combinational helpers only; no flow control here.
package tremolo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAIN = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } t_trem_state;

    localparam logic [16:0] GAIN_ONE  = 17'd32768;
    localparam int          DEPTH_MAX = 16;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        logic signed [15:0] r;
        if (v > 34'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tremolo_gain_calc.sv
// LFO-to-gain mapping: clamp LFO to Q0.15, mix with depth toward unity; purely combinational.
// No state, no flow control; caller registers the result.
module tremolo_gain_calc
    import tremolo_pkg::*;
(
    input  logic signed [15:0] lfo,
    input  logic        [4:0]  depth,
    output logic        [16:0] gain
);

    logic [14:0] lfo_c;
    logic [4:0]  d;
    logic [15:0] inv;
    logic [19:0] mix;

    always_comb begin
        lfo_c = lfo[15] ? 15'd0 : lfo[14:0];
        d     = (depth > 5'(DEPTH_MAX)) ? 5'(DEPTH_MAX) : depth;
        // Distance from unity, scaled by depth/16; max 32768*16 needs 20 bits.
        inv   = 16'd32768 - {1'b0, lfo_c};
        mix   = {4'b0, inv} * {15'b0, d};
        gain  = GAIN_ONE - 17'(mix >> 4);
    end

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo: sample * depth-mixed LFO gain, one shared multiplier, result 3 cycles after strobe.
// No backpressure: strobes arriving while busy are dropped and flagged in sticky o_overrun.
module tremolo_modulator
    import tremolo_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_sample,
    input  logic [DATA_W-1:0]  i_lfo,
    input  logic [DEPTH_W-1:0] i_depth,
    input  logic               i_clr_ovr,
    output logic [DATA_W-1:0]  o_sample,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_overrun
);

    t_trem_state state_q, state_d;

    logic signed [DATA_W-1:0] sample_q;
    logic signed [DATA_W-1:0] lfo_q;
    logic [DEPTH_W-1:0]       depth_q;
    logic [16:0]              gain_c;
    logic [16:0]              gain_q;
    logic signed [33:0]       sample_x;
    logic signed [33:0]       gain_x;
    logic signed [33:0]       prod;
    logic                     accept;
    logic                     ovr_set;

    assign accept  = i_valid && (state_q == S_IDLE);
    assign ovr_set = i_valid && (state_q != S_IDLE);
    assign o_busy  = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_GAIN;
            S_GAIN:  state_d = S_MUL;
            S_MUL:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe-time operands are frozen here; later input changes are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_q <= '0;
            lfo_q    <= '0;
            depth_q  <= '0;
            gain_q   <= '0;
        end else begin
            if (accept) begin
                sample_q <= i_sample;
                lfo_q    <= i_lfo;
                depth_q  <= (i_depth > DEPTH_W'(DEPTH_MAX)) ? DEPTH_W'(DEPTH_MAX) : i_depth;
            end
            if (state_q == S_GAIN) begin
                gain_q <= gain_c;
            end
        end
    end

    tremolo_gain_calc u_gain_calc (
        .lfo   (16'(lfo_q)),
        .depth (5'(depth_q)),
        .gain  (gain_c)
    );

    // Gain is unsigned Q1.15, so it is zero-extended before the signed multiply.
    assign sample_x = {{(34-DATA_W){sample_q[DATA_W-1]}}, sample_q};
    assign gain_x   = {17'b0, gain_q};
    assign prod     = sample_x * gain_x;

    // Output register loads at the end of S_MUL so o_valid and o_sample land together in S_OUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= (state_q == S_MUL);
            if (state_q == S_MUL) begin
                o_sample <= DATA_W'(sat16(prod >>> 15));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (ovr_set) begin
            o_overrun <= 1'b1;
        end else if (i_clr_ovr) begin
            o_overrun <= 1'b0;
        end
    end

endmodule
